ahb_sram_slave: RTL and testbench
=================================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 11: SRAM doubleword index width (16 KiB).
REQ-002 Parameter BASE_ADDR, default 64'h0: region base, aligned to 2^(ADDR_WIDTH+3).
REQ-003 Parameter WAIT_STATES, default 1, range 0..15: extra hreadyout-low cycles per data phase.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 hreset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 hsel  in  1  slave select.
REQ-007 haddr  in  64  byte address.
REQ-008 hwrite  in  1  1=write.
REQ-009 hsize  in  3  0..3 = 1/2/4/8 bytes.
REQ-010 hburst, hprot, hmastlock  in  3/4/1  accepted, ignored.
REQ-011 htrans  in  2  00 IDLE, 01 BUSY, 10 NSEQ, 11 SEQ.
REQ-012 hwdata  in  64  write data, valid in data phase.
REQ-013 hready  in  1  bus ready; address phase ends when high.
REQ-014 hreadyout  out  1  slave ready.
REQ-015 hresp  out  1  0 OKAY, 1 ERROR.
REQ-016 hrdata  out  64  read data.
REQ-017 sram_cs, sram_we  out  1/1  SRAM access strobe / write.
REQ-018 sram_addr  out  ADDR_WIDTH  doubleword index.
REQ-019 sram_be  out  8  byte enables; sram_wdata  out  64  write data.
REQ-020 sram_rdata  in  64  sync SRAM read data, valid the cycle after a read strobe.

Function
REQ-021 Transfer accepted at an edge where hsel & hready & htrans[1]; haddr, hwrite, hsize registered.
REQ-022 IDLE/BUSY, or hsel low: no SRAM access; hreadyout=1, hresp=0 next cycle.
REQ-023 ERROR on accept if haddr[63:ADDR_WIDTH+3] != BASE_ADDR[63:ADDR_WIDTH+3], hsize>3, or haddr not aligned to hsize.
REQ-024 States: IDLE, WR_WAIT, WR_DONE, RD_ISS, RD_CAP, RD_WAIT, RD_DONE, ERR1, ERR2.
REQ-025 Write: WR_WAIT for WAIT_STATES cycles (hreadyout=0), then WR_DONE one cycle (hreadyout=1); WAIT_STATES=0 enters WR_DONE directly.
REQ-026 WR_DONE: sram_cs=1, sram_we=1, sram_addr=haddr_q[ADDR_WIDTH+2:3], sram_wdata=hwdata, sram_be per REQ-029.
REQ-027 Read: RD_ISS (sram_cs=1, we=0) -> RD_CAP (register sram_rdata) -> RD_WAIT for WAIT_STATES cycles -> RD_DONE; hreadyout=0 until RD_DONE.
REQ-028 RD_DONE: hreadyout=1, hrdata=captured word (all 8 lanes); hrdata holds last value otherwise.
REQ-029 sram_be = size mask (01,03,0F,FF) shifted left by haddr_q[2:0], 8-bit truncated.
REQ-030 ERROR: ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1); no SRAM strobe.
REQ-031 From WR_DONE, RD_DONE, ERR2, IDLE: new accept enters next transfer same edge (back-to-back, SEQ or NSEQ); else IDLE.
REQ-032 No accept sampled in any state with hreadyout=0.
REQ-033 SEQ treated exactly as NSEQ; no prefetch, no address increment inside slave.
REQ-034 Wait counter 4 bits, loaded with WAIT_STATES on entry to a wait state, counts down to 0.
REQ-035 sram_cs=0 and sram_we=0 in every state not listed in REQ-026/027.

Reset
REQ-036 hreset_n low: immediately state IDLE, hreadyout=1, hresp=0, hrdata=0, sram_cs=0, sram_we=0, sram_addr=0, sram_be=0, sram_wdata=0, counters 0.
REQ-037 Reset mid-transfer aborts it; no SRAM strobe after reset asserts; first accept allowed at first edge after deassert.

Verification
REQ-038 Reset: hreset_n=0 mid RD_WAIT -> same-cycle hreadyout=1, hresp=0, hrdata=0, sram_cs=0.
REQ-039 WS=1, NSEQ write hsize=3 haddr=0x10 hwdata=0x1122334455667788 -> 1 cycle hreadyout=0, then WR_DONE: sram_we=1, addr=2, be=0xFF.
REQ-040 WS=1, read 0x10 after above -> hreadyout low 3 cycles, 4th cycle hreadyout=1, hrdata=0x1122334455667788.
REQ-041 hsize=0 write haddr=0x13 -> sram_be=0x08; hsize=1 haddr=0x13 -> ERR1 then ERR2, no sram_cs.
REQ-042 haddr=0x4000 (out of range, defaults) -> ERR1 hreadyout=0 hresp=1, ERR2 hreadyout=1 hresp=1, then IDLE OKAY.
REQ-043 WS=0, INCR 4-beat read 0x0..0x18 with BUSY between beats 2 and 3 -> each beat 3 cycles, BUSY zero-wait OKAY, 4 SRAM reads addr 0..3.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master (or interconnect) and the SRAM slave.
// Clock and reset stay outside so one bundle can be reused across instances.
interface ahb_sram_slave_if;
  logic        hsel;
  logic [63:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [1:0]  htrans;
  logic [63:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [63:0] hrdata;

  modport master (
    output hsel, haddr, hwrite, hsize, hburst, hprot, hmastlock, htrans, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, hwrite, hsize, hburst, hprot, hmastlock, htrans, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave fronting a 64-bit synchronous SRAM with programmable wait states.
// One transfer in flight; every data phase is driven by a single registered FSM.
module ahb_sram_slave #(
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  hreset_n,
  ahb_sram_slave_if.slave       ahb,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [7:0]            sram_be,
  output logic [63:0]           sram_wdata,
  input  logic [63:0]           sram_rdata
);

  localparam int unsigned TAG_LSB   = ADDR_WIDTH + 3;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [3:0] {
    IDLE,
    WR_WAIT,
    WR_DONE,
    RD_ISS,
    RD_CAP,
    RD_WAIT,
    RD_DONE,
    ERR1,
    ERR2
  } state_t;

  state_t             state_reg;
  logic [TAG_LSB-1:0] haddr_q;
  logic [2:0]         hsize_q;
  logic [3:0]         wait_cnt_reg;
  logic [63:0]        rdata_q;
  logic               hreadyout_reg;
  logic               hresp_reg;
  logic [63:0]        hrdata_reg;

  logic accept;
  logic tag_ok;
  logic req_err;

  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] offset);
    logic [7:0] m;
    case (size)
      3'd0:    m = 8'h01;
      3'd1:    m = 8'h03;
      3'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << offset;
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [2:0] low);
    case (size)
      3'd1:    return low[0];
      3'd2:    return |low[1:0];
      3'd3:    return |low;
      default: return 1'b0;
    endcase
  endfunction

  // Gating with our own hreadyout keeps stalled states from ever sampling a new address phase.
  assign accept  = ahb.hsel & ahb.hready & ahb.htrans[1] & hreadyout_reg;
  assign tag_ok  = (ahb.haddr[63:TAG_LSB] == BASE_ADDR[63:TAG_LSB]);
  assign req_err = !tag_ok || (ahb.hsize > 3'd3) || misaligned(ahb.hsize, ahb.haddr[2:0]);

  always_ff @(posedge clk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_reg     <= IDLE;
      haddr_q       <= '0;
      hsize_q       <= '0;
      wait_cnt_reg  <= '0;
      rdata_q       <= '0;
      hreadyout_reg <= 1'b1;
      hresp_reg     <= 1'b0;
      hrdata_reg    <= '0;
      sram_cs       <= 1'b0;
      sram_we       <= 1'b0;
      sram_addr     <= '0;
      sram_be       <= '0;
    end else begin
      sram_cs <= 1'b0;
      sram_we <= 1'b0;
      sram_be <= '0;

      case (state_reg)
        // Every hreadyout-high state is a possible end of data phase.
        IDLE, WR_DONE, RD_DONE, ERR2: begin
          if (accept) begin
            haddr_q <= ahb.haddr[TAG_LSB-1:0];
            hsize_q <= ahb.hsize;
            if (req_err) begin
              state_reg     <= ERR1;
              hreadyout_reg <= 1'b0;
              hresp_reg     <= 1'b1;
            end else if (ahb.hwrite) begin
              hresp_reg <= 1'b0;
              if (WAIT_INIT == 4'd0) begin
                state_reg     <= WR_DONE;
                hreadyout_reg <= 1'b1;
                sram_cs       <= 1'b1;
                sram_we       <= 1'b1;
                sram_addr     <= ahb.haddr[TAG_LSB-1:3];
                sram_be       <= lane_mask(ahb.hsize, ahb.haddr[2:0]);
              end else begin
                state_reg     <= WR_WAIT;
                wait_cnt_reg  <= WAIT_INIT;
                hreadyout_reg <= 1'b0;
              end
            end else begin
              state_reg     <= RD_ISS;
              hreadyout_reg <= 1'b0;
              hresp_reg     <= 1'b0;
              sram_cs       <= 1'b1;
              sram_addr     <= ahb.haddr[TAG_LSB-1:3];
            end
          end else begin
            state_reg     <= IDLE;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= 1'b0;
          end
        end

        WR_WAIT: begin
          if (wait_cnt_reg <= 4'd1) begin
            state_reg     <= WR_DONE;
            wait_cnt_reg  <= '0;
            hreadyout_reg <= 1'b1;
            sram_cs       <= 1'b1;
            sram_we       <= 1'b1;
            sram_addr     <= haddr_q[TAG_LSB-1:3];
            sram_be       <= lane_mask(hsize_q, haddr_q[2:0]);
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end

        RD_ISS: begin
          state_reg     <= RD_CAP;
          hreadyout_reg <= 1'b0;
        end

        // sram_rdata is valid in this cycle only; hrdata must not change before RD_DONE.
        RD_CAP: begin
          if (WAIT_INIT == 4'd0) begin
            state_reg     <= RD_DONE;
            hrdata_reg    <= sram_rdata;
            hreadyout_reg <= 1'b1;
          end else begin
            state_reg    <= RD_WAIT;
            rdata_q      <= sram_rdata;
            wait_cnt_reg <= WAIT_INIT;
          end
        end

        RD_WAIT: begin
          if (wait_cnt_reg <= 4'd1) begin
            state_reg     <= RD_DONE;
            wait_cnt_reg  <= '0;
            hrdata_reg    <= rdata_q;
            hreadyout_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end

        ERR1: begin
          state_reg     <= ERR2;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= 1'b1;
        end

        default: begin
          state_reg     <= IDLE;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= 1'b0;
        end
      endcase
    end
  end

  // Write data is only valid in the data phase, so it is passed straight through during the strobe.
  assign sram_wdata    = sram_we ? ahb.hwdata : '0;
  assign ahb.hreadyout = hreadyout_reg;
  assign ahb.hresp     = hresp_reg;
  assign ahb.hrdata    = hrdata_reg;

  logic unused_ok;
  assign unused_ok = ^{ahb.hburst, ahb.hprot, ahb.hmastlock};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: a WS=1 slave for single transfers, errors and reset, and a WS=0
// slave for an INCR4 read burst with a BUSY beat.
module tb_ahb_sram_slave;
  logic clk = 1'b0;
  logic hreset_n = 1'b0;
  always #5 clk = ~clk;

  logic        hsel_a, hsel_b, hwrite;
  logic [63:0] haddr, hwdata;
  logic [2:0]  hsize;
  logic [1:0]  htrans;

  ahb_sram_slave_if if_a ();
  ahb_sram_slave_if if_b ();

  assign if_a.hsel      = hsel_a;
  assign if_a.haddr     = haddr;
  assign if_a.hwrite    = hwrite;
  assign if_a.hsize     = hsize;
  assign if_a.hburst    = 3'b000;
  assign if_a.hprot     = 4'b0011;
  assign if_a.hmastlock = 1'b0;
  assign if_a.htrans    = htrans;
  assign if_a.hwdata    = hwdata;
  assign if_a.hready    = if_a.hreadyout;

  assign if_b.hsel      = hsel_b;
  assign if_b.haddr     = haddr;
  assign if_b.hwrite    = hwrite;
  assign if_b.hsize     = hsize;
  assign if_b.hburst    = 3'b011;
  assign if_b.hprot     = 4'b0011;
  assign if_b.hmastlock = 1'b0;
  assign if_b.htrans    = htrans;
  assign if_b.hwdata    = hwdata;
  assign if_b.hready    = if_b.hreadyout;

  logic        cs_a, we_a, cs_b, we_b;
  logic [10:0] addr_a, addr_b;
  logic [7:0]  be_a, be_b;
  logic [63:0] wdata_a, wdata_b, rdata_a, rdata_b;

  ahb_sram_slave #(.ADDR_WIDTH(11), .BASE_ADDR(64'h0), .WAIT_STATES(1)) dut_a (
    .clk(clk), .hreset_n(hreset_n), .ahb(if_a),
    .sram_cs(cs_a), .sram_we(we_a), .sram_addr(addr_a), .sram_be(be_a),
    .sram_wdata(wdata_a), .sram_rdata(rdata_a)
  );

  ahb_sram_slave #(.ADDR_WIDTH(11), .BASE_ADDR(64'h0), .WAIT_STATES(0)) dut_b (
    .clk(clk), .hreset_n(hreset_n), .ahb(if_b),
    .sram_cs(cs_b), .sram_we(we_b), .sram_addr(addr_b), .sram_be(be_b),
    .sram_wdata(wdata_b), .sram_rdata(rdata_b)
  );

  // Byte-enabled synchronous SRAM behind slave A.
  logic [63:0] mem_a [0:2047];
  always @(posedge clk) begin
    if (cs_a) begin
      if (we_a) begin
        logic [63:0] w;
        w = mem_a[addr_a];
        for (int i = 0; i < 8; i++)
          if (be_a[i]) w[8*i +: 8] = wdata_a[8*i +: 8];
        mem_a[addr_a] <= w;
      end else begin
        rdata_a <= mem_a[addr_a];
      end
    end
  end

  // Slave B's SRAM returns a word tagged with the doubleword index it was asked for.
  always @(posedge clk) begin
    if (cs_b && !we_b) rdata_b <= {32'hB0B0_B0B0, 21'd0, addr_b};
  end

  int cs_cnt_a = 0;
  int cs_cnt_b = 0;
  always @(posedge clk) begin
    if (cs_a) cs_cnt_a <= cs_cnt_a + 1;
    if (cs_b) cs_cnt_b <= cs_cnt_b + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sa, input logic sb, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [63:0] ad);
    hsel_a = sa;
    hsel_b = sb;
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
    haddr  = ad;
  endtask

  // Leaves slave A in WR_DONE so a following transfer can go back-to-back.
  task automatic write_a(input logic [63:0] ad, input logic [2:0] sz, input logic [63:0] data,
                         input logic [7:0] exp_be);
    drive(1'b1, 1'b0, 2'b10, 1'b1, sz, ad);
    step();
    check("wr_wait_rdy", 64'(if_a.hreadyout), 64'd0);
    check("wr_wait_cs", 64'(cs_a), 64'd0);
    hwdata = data;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 64'd0);
    step();
    check("wr_done_rdy", 64'(if_a.hreadyout), 64'd1);
    check("wr_done_cs", 64'(cs_a), 64'd1);
    check("wr_done_we", 64'(we_a), 64'd1);
    check("wr_done_addr", 64'(addr_a), 64'(ad[13:3]));
    check("wr_done_be", 64'(be_a), 64'(exp_be));
    check("wr_done_wdata", wdata_a, data);
    $display("WR   addr=%h size=%0d data=%h be=%h", ad, sz, data, be_a);
  endtask

  // Leaves slave A in RD_DONE.
  task automatic read_a(input logic [63:0] ad, input logic [63:0] exp);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 3'd3, ad);
    step();
    check("rd_iss_rdy", 64'(if_a.hreadyout), 64'd0);
    check("rd_iss_cs", 64'(cs_a), 64'd1);
    check("rd_iss_we", 64'(we_a), 64'd0);
    check("rd_iss_addr", 64'(addr_a), 64'(ad[13:3]));
    drive(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 64'd0);
    step();
    check("rd_cap_rdy", 64'(if_a.hreadyout), 64'd0);
    step();
    check("rd_wait_rdy", 64'(if_a.hreadyout), 64'd0);
    step();
    check("rd_done_rdy", 64'(if_a.hreadyout), 64'd1);
    check("rd_done_resp", 64'(if_a.hresp), 64'd0);
    check("rd_done_data", if_a.hrdata, exp);
    $display("RD   addr=%h data=%h", ad, if_a.hrdata);
  endtask

  task automatic err_a(input logic [63:0] ad, input logic [2:0] sz, input logic wr);
    int c0;
    c0 = cs_cnt_a;
    drive(1'b1, 1'b0, 2'b10, wr, sz, ad);
    step();
    check("err1_rdy", 64'(if_a.hreadyout), 64'd0);
    check("err1_resp", 64'(if_a.hresp), 64'd1);
    check("err1_cs", 64'(cs_a), 64'd0);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 64'd0);
    step();
    check("err2_rdy", 64'(if_a.hreadyout), 64'd1);
    check("err2_resp", 64'(if_a.hresp), 64'd1);
    check("err2_cs", 64'(cs_a), 64'd0);
    step();
    check("err_idle_rdy", 64'(if_a.hreadyout), 64'd1);
    check("err_idle_resp", 64'(if_a.hresp), 64'd0);
    check("err_strobes", 64'(cs_cnt_a - c0), 64'd0);
    $display("ERR  addr=%h size=%0d write=%0d", ad, sz, wr);
  endtask

  // One WS=0 read beat on slave B: RD_ISS, RD_CAP, RD_DONE.
  task automatic beat_b(input logic [1:0] tr, input logic [63:0] ad);
    drive(1'b0, 1'b1, tr, 1'b0, 3'd3, ad);
    step();
    check("b_iss_rdy", 64'(if_b.hreadyout), 64'd0);
    check("b_iss_cs", 64'(cs_b), 64'd1);
    check("b_iss_addr", 64'(addr_b), 64'(ad[13:3]));
    step();
    check("b_cap_rdy", 64'(if_b.hreadyout), 64'd0);
    step();
    check("b_done_rdy", 64'(if_b.hreadyout), 64'd1);
    check("b_done_data", if_b.hrdata, 64'hB0B0_B0B0_0000_0000 | (ad >> 3));
    $display("BRD  addr=%h data=%h", ad, if_b.hrdata);
  endtask

  initial begin
    int c0;
    hwdata = 64'd0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 64'd0);
    step();
    step();
    check("rst_rdy", 64'(if_a.hreadyout), 64'd1);
    check("rst_resp", 64'(if_a.hresp), 64'd0);
    check("rst_hrdata", if_a.hrdata, 64'd0);
    check("rst_cs", 64'(cs_a), 64'd0);
    check("rst_be", 64'(be_a), 64'd0);
    check("rst_addr", 64'(addr_a), 64'd0);
    hreset_n = 1'b1;

    write_a(64'h10, 3'd3, 64'h1122_3344_5566_7788, 8'hFF);
    step();
    check("idle_rdy", 64'(if_a.hreadyout), 64'd1);
    check("idle_cs", 64'(cs_a), 64'd0);

    read_a(64'h10, 64'h1122_3344_5566_7788);
    step();
    check("rd_hold", if_a.hrdata, 64'h1122_3344_5566_7788);

    write_a(64'h13, 3'd0, 64'h0000_0000_AB00_0000, 8'h08);
    step();
    err_a(64'h13, 3'd1, 1'b1);
    read_a(64'h10, 64'h1122_3344_AB66_7788);
    step();
    err_a(64'h4000, 3'd3, 1'b0);

    // Back-to-back write, write, read.
    write_a(64'h20, 3'd3, 64'h0, 8'hFF);
    write_a(64'h24, 3'd2, 64'hDEAD_BEEF_0000_0000, 8'hF0);
    read_a(64'h20, 64'hDEAD_BEEF_0000_0000);
    step();

    // Asynchronous reset in the middle of a read's wait state.
    drive(1'b1, 1'b0, 2'b10, 1'b0, 3'd3, 64'h10);
    step();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 64'd0);
    step();
    step();
    check("pre_rst_rdy", 64'(if_a.hreadyout), 64'd0);
    #2 hreset_n = 1'b0;
    #1;
    check("arst_rdy", 64'(if_a.hreadyout), 64'd1);
    check("arst_resp", 64'(if_a.hresp), 64'd0);
    check("arst_hrdata", if_a.hrdata, 64'd0);
    check("arst_cs", 64'(cs_a), 64'd0);
    c0 = cs_cnt_a;
    step();
    check("arst_edge_cs", 64'(cs_a), 64'd0);
    hreset_n = 1'b1;
    read_a(64'h10, 64'h1122_3344_AB66_7788);
    check("arst_strobes", 64'(cs_cnt_a - c0), 64'd1);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 64'd0);
    step();

    // INCR4 read burst on the zero-wait slave with BUSY between beats 2 and 3.
    c0 = cs_cnt_b;
    beat_b(2'b10, 64'h00);
    beat_b(2'b11, 64'h08);
    drive(1'b0, 1'b1, 2'b01, 1'b0, 3'd3, 64'h10);
    step();
    check("busy_rdy", 64'(if_b.hreadyout), 64'd1);
    check("busy_resp", 64'(if_b.hresp), 64'd0);
    check("busy_cs", 64'(cs_b), 64'd0);
    $display("BUSY addr=%h", haddr);
    beat_b(2'b11, 64'h10);
    beat_b(2'b11, 64'h18);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 64'd0);
    step();
    check("burst_strobes", 64'(cs_cnt_b - c0), 64'd4);
    check("burst_idle_rdy", 64'(if_b.hreadyout), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
